// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - opcodes, error codes, default widths and FSM states for the matrix engine
package matrix_pkg;
   localparam int ELEMENT_WIDTH_DEF = 8;
   localparam int BRAM_ADDR_WIDTH   = 10;

   localparam logic [3:0] OP_ADD       = 4'd0;
   localparam logic [3:0] OP_TRANSPOSE = 4'd1;
   localparam logic [3:0] OP_SCALAR    = 4'd2;
   localparam logic [3:0] OP_MUL       = 4'd3;

   localparam logic [3:0] ERR_NONE         = 4'd0;
   localparam logic [3:0] ERR_DIM_MISMATCH = 4'd1;
   localparam logic [3:0] ERR_INVALID_OP   = 4'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ELEM,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;
endpackage

// File: rtl/matrix_addr_gen.sv
// rtl/matrix_addr_gen.sv - combinational row-major read/write address generation
module matrix_addr_gen
   import matrix_pkg::*;
#(
   parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH
) (
   input  logic [3:0]            op,
   input  logic [3:0]            a_n,
   input  logic [3:0]            b_n,
   input  logic [3:0]            res_n,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [ADDR_WIDTH-1:0] res_addr,
   input  logic [3:0]            i,
   input  logic [3:0]            j,
   input  logic [4:0]            r,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH-1:0] wr_addr
);
   logic [3:0] k;
   assign k = r[4:1];

   function automatic logic [ADDR_WIDTH-1:0] lin(input logic [ADDR_WIDTH-1:0] base,
                                                 input logic [3:0] row,
                                                 input logic [3:0] cols,
                                                 input logic [3:0] col);
      return base + ADDR_WIDTH'(row) * ADDR_WIDTH'(cols) + ADDR_WIDTH'(col);
   endfunction

   // r is the read index within an element; for MUL even reads hit A, odd reads hit B
   always_comb begin
      rd_addr = lin(a_addr, i, a_n, j);
      case (op)
         OP_ADD:       if (r[0]) rd_addr = lin(b_addr, i, a_n, j);
         OP_TRANSPOSE: rd_addr = lin(a_addr, j, a_n, i);
         OP_MUL:       rd_addr = r[0] ? lin(b_addr, k, b_n, j) : lin(a_addr, i, a_n, k);
         default:      ;
      endcase
   end

   assign wr_addr = lin(res_addr, i, res_n, j);
endmodule

// File: rtl/matrix_exec_engine.sv
// rtl/matrix_exec_engine.sv - compute-mode execution engine: reads operands from BRAM, writes result
module matrix_exec_engine
   import matrix_pkg::*;
#(
   parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
   parameter int ADDR_WIDTH    = BRAM_ADDR_WIDTH,
   parameter int ACC_WIDTH     = 2*ELEMENT_WIDTH+4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [3:0]               op_type,
   input  logic [3:0]               a_m,
   input  logic [3:0]               a_n,
   input  logic [ADDR_WIDTH-1:0]    a_addr,
   input  logic [3:0]               b_m,
   input  logic [3:0]               b_n,
   input  logic [ADDR_WIDTH-1:0]    b_addr,
   input  logic [ELEMENT_WIDTH-1:0] scalar,
   input  logic [ADDR_WIDTH-1:0]    res_addr,
   output logic                     mem_rd_en,
   output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
   input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
   output logic                     mem_wr_en,
   output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
   output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [3:0]               error_code,
   output logic [3:0]               res_m,
   output logic [3:0]               res_n
);
   state_t state, next_state;

   logic [3:0]                      op_q, a_m_q, a_n_q, b_m_q, b_n_q;
   logic [ADDR_WIDTH-1:0]           a_addr_q, b_addr_q, res_addr_q;
   logic signed [ELEMENT_WIDTH-1:0] scalar_q, a_hold_q, rd_s;
   logic [3:0]                      i_q, j_q;
   logic [4:0]                      r_q, r_last;
   logic signed [ACC_WIDTH-1:0]     acc_q, term, acc_sum;
   logic signed [2*ELEMENT_WIDTH-1:0] sc_prod, mul_prod;
   logic [3:0]                      err_chk;
   logic                            last_elem;
   logic [ADDR_WIDTH-1:0]           rd_addr_w, wr_addr_w;

   matrix_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
      .op(op_q), .a_n(a_n_q), .b_n(b_n_q), .res_n(res_n),
      .a_addr(a_addr_q), .b_addr(b_addr_q), .res_addr(res_addr_q),
      .i(i_q), .j(j_q), .r(r_q),
      .rd_addr(rd_addr_w), .wr_addr(wr_addr_w)
   );

   always_comb begin
      err_chk = ERR_NONE;
      if (op_q > OP_MUL)
         err_chk = ERR_INVALID_OP;
      else if (a_m_q == 4'd0 || a_n_q == 4'd0)
         err_chk = ERR_DIM_MISMATCH;
      else if ((op_q == OP_ADD || op_q == OP_MUL) && (b_m_q == 4'd0 || b_n_q == 4'd0))
         err_chk = ERR_DIM_MISMATCH;
      else if (op_q == OP_ADD && (a_m_q != b_m_q || a_n_q != b_n_q))
         err_chk = ERR_DIM_MISMATCH;
      else if (op_q == OP_MUL && a_n_q != b_m_q)
         err_chk = ERR_DIM_MISMATCH;
   end

   always_comb begin
      r_last = 5'd0;
      case (op_q)
         OP_ADD:  r_last = 5'd1;
         OP_MUL:  r_last = {a_n_q, 1'b0} - 5'd1;
         default: r_last = 5'd0;
      endcase
   end

   // Data arriving now belongs to read r_q-1; for MUL an even r_q means a B operand arrived
   assign rd_s     = mem_rd_data;
   assign sc_prod  = rd_s * scalar_q;
   assign mul_prod = a_hold_q * rd_s;

   always_comb begin
      term = {{(ACC_WIDTH-ELEMENT_WIDTH){rd_s[ELEMENT_WIDTH-1]}}, rd_s};
      case (op_q)
         OP_SCALAR: term = {{(ACC_WIDTH-2*ELEMENT_WIDTH){sc_prod[2*ELEMENT_WIDTH-1]}}, sc_prod};
         OP_MUL:    term = r_q[0] ? '0
                         : {{(ACC_WIDTH-2*ELEMENT_WIDTH){mul_prod[2*ELEMENT_WIDTH-1]}}, mul_prod};
         default:   ;
      endcase
   end

   assign acc_sum   = acc_q + term;
   assign last_elem = (i_q == res_m - 4'd1) && (j_q == res_n - 4'd1);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      case (state)
         S_IDLE:  if (start) next_state = S_CHECK;
         S_CHECK: begin
            busy       = 1'b1;
            next_state = (err_chk != ERR_NONE) ? S_ERR : S_ELEM;
         end
         S_ELEM: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            if (r_q == r_last) next_state = S_WRITE;
         end
         S_WRITE: begin
            busy       = 1'b1;
            mem_wr_en  = 1'b1;
            next_state = last_elem ? S_DONE : S_ELEM;
         end
         S_DONE, S_ERR: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   assign mem_rd_addr = mem_rd_en ? rd_addr_w : '0;
   assign mem_wr_addr = mem_wr_en ? wr_addr_w : '0;
   assign mem_wr_data = mem_wr_en ? acc_sum[ELEMENT_WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= '0; a_m_q <= '0; a_n_q <= '0; b_m_q <= '0; b_n_q <= '0;
         a_addr_q <= '0; b_addr_q <= '0; res_addr_q <= '0; scalar_q <= '0;
         i_q <= '0; j_q <= '0; r_q <= '0; acc_q <= '0; a_hold_q <= '0;
         error_code <= ERR_NONE; res_m <= '0; res_n <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op_q <= op_type; a_m_q <= a_m; a_n_q <= a_n; b_m_q <= b_m; b_n_q <= b_n;
               a_addr_q <= a_addr; b_addr_q <= b_addr; res_addr_q <= res_addr;
               scalar_q <= scalar;
            end
            S_CHECK: begin
               error_code <= err_chk;
               i_q <= '0; j_q <= '0; r_q <= '0; acc_q <= '0;
               if (err_chk == ERR_NONE) begin
                  res_m <= (op_q == OP_TRANSPOSE) ? a_n_q : a_m_q;
                  res_n <= (op_q == OP_TRANSPOSE) ? a_m_q : (op_q == OP_MUL) ? b_n_q : a_n_q;
               end else begin
                  res_m <= '0;
                  res_n <= '0;
               end
            end
            S_ELEM: begin
               r_q <= r_q + 5'd1;
               if (r_q != 5'd0) begin
                  acc_q <= acc_sum;
                  if (op_q == OP_MUL && r_q[0]) a_hold_q <= rd_s;
               end
            end
            S_WRITE: begin
               acc_q <= '0;
               r_q   <= '0;
               if (j_q == res_n - 4'd1) begin
                  j_q <= '0;
                  i_q <= i_q + 4'd1;
               end else begin
                  j_q <= j_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
